uart_loop_buffer: RTL and testbench
===================================

# uart_loop_buffer

Buffered byte path between the UART receiver and the UART transmitter. It captures each received byte on the rising edge of the receiver's status strobe, optionally applies the odd-byte inversion rule, and queues the byte in a small FIFO. It launches one transmitter job per queued byte, using an explicit busy/idle handshake, so back-to-back received bytes are not lost while the transmitter is busy.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256.
- XFORM_EN, 1: 1 = a byte with bit0==1 is stored as its bitwise inverse (~byte); 0 = pass-through.
- ACK_TIMEOUT, 1023: clk cycles to wait for tx_ready to fall after a launch.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high; clock clk.
- rx_valid  in  1  receiver status; level, may stay high for many cycles per byte.
- rx_data  in  8  received byte; stable while rx_valid is high.
- tx_ready  in  1  transmitter idle (1) / busy (0).
- tx_en  out  1  one-cycle launch pulse.
- tx_data  out  8  byte to send; held stable from the tx_en cycle until tx_ready returns high.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.
- ack_err  out  1  sticky; set on an ACK_TIMEOUT expiry.

## Operation
- Capture: rx_valid is registered once as rv_q. A capture occurs when rx_valid & ~rv_q (rising edge); exactly one push per edge.
- Push data: rx_data, transformed if XFORM_EN=1 (0x01→0xFE, 0x42→0x42, 0xFF→0x00).
- FIFO: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping naturally; level counts 0..DEPTH.
- Full: when level==DEPTH, a push is dropped, overflow←1, and level is unchanged.
- Empty: a pop is never issued while level==0.
- Simultaneous push+pop: both happen and level is unchanged. When full, a push in the same cycle as a pop is accepted (no overflow).
- FSM states:
  - IDLE: if level!=0 && tx_ready → LAUNCH. tx_data←head, pop.
  - LAUNCH: tx_en=1 for this cycle only → WAIT_BUSY. Timeout counter cleared.
  - WAIT_BUSY: if tx_ready==0 → WAIT_DONE. Otherwise the counter increments; at ACK_TIMEOUT set ack_err and → IDLE (the byte is considered lost).
  - WAIT_DONE: if tx_ready==1 → IDLE.
- The transmitter's tx_ready may fall before LAUNCH ends; WAIT_BUSY then exits on its first cycle.
- Reset values: tx_en=0, tx_data=0x00, level=0, overflow=0, ack_err=0, state=IDLE, rv_q=1. rv_q=1 means an rx_valid already high at reset release is not captured.
- Reset mid-operation: queue contents are discarded and any in-flight byte is abandoned. The transmitter finishes its current frame independently.
- Sticky flags clear only on reset.

## Timing
- Capture latency: rx_valid rising at edge n → level increments at edge n+1 (rv_q compare) → entry visible at edge n+2.
- Launch latency: with the FIFO non-empty and tx_ready=1 in IDLE at edge k, tx_data is valid and tx_en=1 after edge k+1; tx_en drops after edge k+2.
- Minimum spacing between tx_en pulses: 3 clk cycles plus the transmitter busy time.
- At most one pop per launch; pops occur only in the IDLE→LAUNCH transition.
- Throughput is bounded by the transmitter. A 9600-baud frame is about 52 080 clk cycles, so the FIFO absorbs bursts only.

## Structure
- Shared package uart_pkg: BYTE_W=8, the state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE), and the function xform_byte(byte, en).
- Sub-module uart_byte_fifo: DEPTH parameter; push/pop/din/dout/level/full/empty. Reusable by a future RX-side parser.
- Top level holds edge detect, transform, FSM, timeout counter, and sticky flags.

## Test plan
- Single byte: with tx_ready=1, pulse rx_valid high for 800 cycles with 0x43 → exactly one tx_en pulse, tx_data=0xBC, level returns to 0.
- Pass-through: XFORM_EN=0 and 0x55 → tx_data=0x55. XFORM_EN=1 and 0x42 → tx_data=0x42.
- Burst: hold tx_ready=0 and push 16 bytes 0x00..0x0F (DEPTH=16) → level=16 and overflow=0. A 17th byte → overflow=1 and level=16. Then toggle tx_ready with a busy of 100 cycles per byte → 16 bytes out in order, all transformed.
- Simultaneous: FIFO full, rx edge in the same cycle as the IDLE→LAUNCH pop → level stays 16 and overflow stays 0.
- Timeout: tx_ready stuck at 1 after launch → ack_err=1 after ACK_TIMEOUT cycles, FSM back in IDLE, next byte launched.
- Reset mid-flight: reset asserted in WAIT_DONE with level=5 → next cycle level=0, tx_en=0, tx_data=0x00, flags cleared. rx_valid held high through the reset release → no capture.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte path: byte width, loop-buffer FSM
// states and the odd-byte inversion rule.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // A byte whose bit0 is set is replaced by its bitwise inverse when enabled.
  function automatic logic [BYTE_W-1:0] xform_byte(input logic [BYTE_W-1:0] data,
                                                   input logic en);
    return (en && data[0]) ? ~data : data;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small circular byte FIFO with an occupancy count. A push while full is
// accepted only when a pop happens in the same cycle; a pop while empty is
// ignored. dout shows the head entry combinationally.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        din,
  output logic [BYTE_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally; level tracks the push/pop balance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_loop_buffer.sv
// Buffered byte path from UART receiver to UART transmitter.
// Receive side: one capture per rising edge of the rx_valid level.
// Transmit side handshake: tx_en is a one-cycle launch pulse with tx_data held
// until the job ends; the transmitter answers by dropping tx_ready (busy) and
// later raising it (idle). A launch is issued only while tx_ready is high, and
// a launch that never sees tx_ready fall within ACK_TIMEOUT cycles is
// abandoned and flagged on ack_err.
module uart_loop_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int XFORM_EN    = 1,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [BYTE_W-1:0]      rx_data,
  input  logic                   tx_ready,
  output logic                   tx_en,
  output logic [BYTE_W-1:0]      tx_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   ack_err,
  output state_t                 state
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic              rv_q;
  logic              capture;
  logic              pop;
  logic              full;
  logic              empty;
  logic [BYTE_W-1:0] push_data;
  logic [BYTE_W-1:0] head;
  logic [CW-1:0]     cnt;

  assign capture   = rx_valid & ~rv_q;
  assign push_data = xform_byte(rx_data, XFORM_EN != 0);
  assign pop       = (state == IDLE) && !empty && tx_ready;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .din   (push_data),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Edge detector history; resets high so a level already present is ignored.
  always_ff @(posedge clk) begin
    if (reset) rv_q <= 1'b1;
    else       rv_q <= rx_valid;
  end

  // Sticky drop flag: a capture into a full FIFO with no pop to make room.
  always_ff @(posedge clk) begin
    if (reset)                         overflow <= 1'b0;
    else if (capture && full && !pop)  overflow <= 1'b1;
  end

  // Launch FSM with registered tx_en/tx_data, timeout counter and ack_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
      cnt     <= '0;
      ack_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= head;
            tx_en   <= 1'b1;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_en <= 1'b0;
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_ready) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            ack_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (tx_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loop_buffer.sv
// Directed bench for uart_loop_buffer with a behavioural transmitter and an
// expected-byte queue checked on every launch.
module tb_uart_loop_buffer;
  import uart_pkg::*;

  localparam int DEPTH    = 16;
  localparam int ACK_TO   = 1023;
  localparam int BUSY_CYC = 100;
  localparam int MODE_LOW  = 0;  // transmitter stalled busy
  localparam int MODE_HIGH = 1;  // transmitter stuck idle, never acknowledges
  localparam int MODE_AUTO = 2;  // transmitter accepts each launch, busy BUSY_CYC

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT A (transform enabled) ----------------
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [4:0] level;
  logic       overflow;
  logic       ack_err;
  state_t     state;

  uart_loop_buffer #(.DEPTH(DEPTH), .XFORM_EN(1), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_en(tx_en), .tx_data(tx_data), .level(level),
    .overflow(overflow), .ack_err(ack_err), .state(state)
  );

  // ---------------- DUT B (pass-through) ----------------
  logic       rx_valid_b;
  logic [7:0] rx_data_b;
  logic       tx_ready_b;
  logic       tx_en_b;
  logic [7:0] tx_data_b;
  logic [4:0] level_b;
  logic       overflow_b;
  logic       ack_err_b;
  state_t     state_b;

  uart_loop_buffer #(.DEPTH(DEPTH), .XFORM_EN(0), .ACK_TIMEOUT(ACK_TO)) dut_b (
    .clk(clk), .reset(reset), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .tx_ready(tx_ready_b), .tx_en(tx_en_b), .tx_data(tx_data_b), .level(level_b),
    .overflow(overflow_b), .ack_err(ack_err_b), .state(state_b)
  );

  // ---------------- transmitter model / scoreboard state ----------------
  int tx_mode;
  int busy;
  assign tx_ready = (tx_mode == MODE_AUTO) ? (busy == 0) : (tx_mode == MODE_HIGH);

  logic [7:0] exp_q[$];
  int n_compared;
  int n_failed;
  int cyc;
  int tx_count;
  int launch_cyc;
  int count_b;
  logic [7:0] data_b;
  logic prev_tx_en;

  function automatic logic [7:0] model_xform(input logic [7:0] b);
    if (b[0]) return ~b;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance to the falling edge, run the transmitter, watch launches.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (tx_mode == MODE_AUTO && tx_en) busy = BUSY_CYC;
    else if (busy > 0) busy--;
    if (!reset && tx_en) begin
      tx_count++;
      launch_cyc = cyc;
      check("tx_en_one_cycle", 32'(prev_tx_en), 32'd0);
      n_compared++;
      assert (exp_q.size() > 0) else begin
        n_failed++;
        $error("FAIL tx_unexpected: observed launch of 0x%0h expected no launch", tx_data);
      end
      if (exp_q.size() > 0) check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    prev_tx_en = tx_en;
    if (tx_en_b) begin
      count_b++;
      data_b = tx_data_b;
    end
  endtask

  // Drive one received byte on DUT A: level high for 'hold' cycles, then low.
  task automatic send_byte(input logic [7:0] b, input int hold, input bit expect_out);
    if (expect_out) exp_q.push_back(model_xform(b));
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) step();
    rx_valid = 1'b0;
    repeat (2) step();
  endtask

  // Wait (bounded) until DUT A is drained and idle.
  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (!(level == 0 && state == IDLE && tx_ready && exp_q.size() == 0) && n < limit) begin
      step();
      n++;
    end
    check(tag, 32'(n < limit), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int base;
    n_compared = 0; n_failed = 0; cyc = 0; tx_count = 0; launch_cyc = 0;
    count_b = 0; data_b = '0; prev_tx_en = 1'b0; busy = 0;
    tx_mode = MODE_LOW;
    reset = 1'b1;
    rx_valid = 1'b0; rx_data = '0;
    rx_valid_b = 1'b0; rx_data_b = '0; tx_ready_b = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    reset = 1'b0;
    repeat (2) step();

    // Pass-through instance: 0x55 leaves unchanged
    rx_data_b = 8'h55; rx_valid_b = 1'b1;
    repeat (3) step();
    rx_valid_b = 1'b0;
    n = 0;
    while (count_b == 0 && n < 20) begin step(); n++; end
    check("pt_launched", 32'(count_b), 32'd1);
    check("pt_tx_data", 32'(data_b), 32'h55);

    // Single byte, long rx_valid level: exactly one launch, 0x43 -> 0xBC
    tx_mode = MODE_AUTO;
    base = tx_count;
    send_byte(8'h43, 800, 1'b1);
    wait_idle("single_drain", 400);
    check("single_one_launch", 32'(tx_count - base), 32'd1);
    check("single_tx_data", 32'(tx_data), 32'hBC);
    check("single_level", 32'(level), 32'd0);

    // Even byte is not inverted
    send_byte(8'h42, 3, 1'b1);
    wait_idle("even_drain", 400);
    check("even_tx_data", 32'(tx_data), 32'h42);

    // Burst into a stalled transmitter: fill to DEPTH
    tx_mode = MODE_LOW;
    base = tx_count;
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 2, 1'b1);
    check("burst_level_full", 32'(level), 32'(DEPTH));
    check("burst_no_overflow", 32'(overflow), 32'd0);
    check("burst_no_launch", 32'(tx_count - base), 32'd0);

    // Capture in the same cycle as the first pop while full
    tx_mode  = MODE_AUTO;
    exp_q.push_back(model_xform(8'h21));
    rx_data  = 8'h21;
    rx_valid = 1'b1;
    step();
    check("simul_level", 32'(level), 32'(DEPTH));
    check("simul_overflow", 32'(overflow), 32'd0);
    rx_valid = 1'b0;
    step();

    // 17th byte while full and transmitter busy: dropped
    rx_data  = 8'h10;
    rx_valid = 1'b1;
    step();
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'(DEPTH));
    rx_valid = 1'b0;
    step();

    // Drain: all bytes in order, transformed
    wait_idle("burst_drain", 4000);
    check("burst_launch_count", 32'(tx_count - base), 32'(DEPTH + 1));
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Timeout: transmitter never goes busy
    tx_mode = MODE_HIGH;
    send_byte(8'h07, 2, 1'b1);
    n = 0;
    while (!ack_err && n < 2000) begin step(); n++; end
    check("ack_err_set", 32'(ack_err), 32'd1);
    check("ack_latency_ok", 32'((cyc - launch_cyc) >= ACK_TO && (cyc - launch_cyc) <= ACK_TO + 4), 32'd1);
    check("ack_state_idle", 32'(state), 32'(IDLE));
    tx_mode = MODE_AUTO;
    base = tx_count;
    send_byte(8'h80, 2, 1'b1);
    wait_idle("after_timeout_drain", 400);
    check("after_timeout_launch", 32'(tx_count - base), 32'd1);
    check("ack_err_sticky", 32'(ack_err), 32'd1);

    // Reset mid-flight in WAIT_DONE with five bytes waiting
    tx_mode = MODE_LOW;
    for (int i = 0; i < 6; i++) send_byte(8'h31 + 8'(i), 2, 1'b1);
    check("mid_level6", 32'(level), 32'd6);
    tx_mode = MODE_AUTO;
    n = 0;
    while (state != WAIT_DONE && n < 10) begin step(); n++; end
    check("mid_in_wait_done", 32'(state), 32'(WAIT_DONE));
    check("mid_level5", 32'(level), 32'd5);
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    reset    = 1'b1;
    step();
    exp_q.delete();
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_tx_en", 32'(tx_en), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'h00);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_ack_err", 32'(ack_err), 32'd0);
    check("mid_rst_state", 32'(state), 32'(IDLE));
    reset = 1'b0;
    base  = tx_count;
    repeat (150) step();
    check("held_valid_no_capture", 32'(level), 32'd0);
    check("held_valid_no_launch", 32'(tx_count - base), 32'd0);
    rx_valid = 1'b0;
    repeat (2) step();

    // Operational again after reset: 0x01 -> 0xFE
    send_byte(8'h01, 2, 1'b1);
    wait_idle("post_reset_drain", 400);
    check("post_reset_tx_data", 32'(tx_data), 32'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
